// File: rtl/tri_solve_if.sv
// Request/result bundle for the triangular solver: operands and start in, status and solution out.
interface tri_solve_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic             start;
  logic             mode;
  logic [N*N*W-1:0] A_in;
  logic [N*W-1:0]   b_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [N*W-1:0]   y_out;

  modport master (
    output start, mode, A_in, b_in,
    input  busy, done, err, y_out
  );

  modport slave (
    input  start, mode, A_in, b_in,
    output busy, done, err, y_out
  );
endinterface

// File: rtl/tri_solve_nxn.sv
// Sequential NxN triangular solver: forward (lower) or back (upper) substitution,
// one signed MAC per cycle and one divide per row, sticky divide-by-zero flag.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_MAC  | accumulating one off-diagonal term of the current row per cycle
//   S_DIV  | dividing the row accumulator by the diagonal, writing y[row]
//   S_DONE | one-cycle done pulse; a new start may be accepted here
module tri_solve_nxn #(
  parameter int N = 4,
  parameter int W = 32
) (
  input logic       clk,
  input logic       rst,
  tri_solve_if.slave bus
);
  localparam int RW = $clog2(N);
  localparam int AW = 2*W + RW;
  localparam logic [RW-1:0] ONE     = RW'(1);
  localparam logic [RW-1:0] ROW_BOT = RW'(N-1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DIV, S_DONE} state_t;

  state_t state_q, state_d;
  logic                 mode_q;
  logic [RW-1:0]        row_q, col_q;
  logic signed [AW-1:0] acc_q;
  logic signed [W-1:0]  a_m [N][N];
  logic signed [W-1:0]  b_m [N];
  logic signed [W-1:0]  y_m [N];
  logic                 err_q;

  logic                   accept, last_term, last_row, diag_zero;
  logic signed [W-1:0]    a_rc, a_rr, b_first, b_nx;
  logic signed [2*W-1:0]  prod;
  logic signed [AW-1:0]   div_s, quo;
  logic [RW-1:0]          row_nx, col_first;

  always_comb begin
    a_rc      = a_m[row_q][col_q];
    a_rr      = a_m[row_q][row_q];
    prod      = a_rc * y_m[col_q];
    diag_zero = (a_rr == '0);
    div_s     = {{(AW-W){a_rr[W-1]}}, a_rr};
    // Keep the divider operand legal; the result is discarded on a zero diagonal.
    if (diag_zero) div_s = AW'(1);
    quo       = acc_q / div_s;
    last_term = mode_q ? (col_q == row_q + ONE) : (col_q == row_q - ONE);
    last_row  = mode_q ? (row_q == '0) : (row_q == ROW_BOT);
    row_nx    = mode_q ? row_q - ONE : row_q + ONE;
    col_first = mode_q ? ROW_BOT : '0;
    b_nx      = b_m[row_nx];
    b_first   = bus.mode ? bus.b_in[(N-1)*W +: W] : bus.b_in[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        // The first row of either direction has no off-diagonal terms.
        if (bus.start) begin
          accept  = 1'b1;
          state_d = S_DIV;
        end
      end
      S_MAC:   if (last_term) state_d = S_DIV;
      S_DIV:   state_d = last_row ? S_DONE : S_MAC;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N; i++) y_m[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q <= bus.mode;
        err_q  <= 1'b0;
        row_q  <= bus.mode ? ROW_BOT : '0;
        acc_q  <= {{(AW-W){b_first[W-1]}}, b_first};
        for (int i = 0; i < N; i++) y_m[i] <= '0;
      end else begin
        case (state_q)
          S_MAC: begin
            acc_q <= acc_q - {{RW{prod[2*W-1]}}, prod};
            col_q <= mode_q ? col_q - ONE : col_q + ONE;
          end
          S_DIV: begin
            y_m[row_q] <= diag_zero ? '0 : quo[W-1:0];
            if (diag_zero) err_q <= 1'b1;
            if (!last_row) begin
              row_q <= row_nx;
              col_q <= col_first;
              acc_q <= {{(AW-W){b_nx[W-1]}}, b_nx};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Operand snapshot: only written on an accepted start, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) a_m[r][c] <= bus.A_in[(r*N+c)*W +: W];
        b_m[r] <= bus.b_in[r*W +: W];
      end
    end
  end

  assign bus.busy = (state_q == S_MAC) || (state_q == S_DIV);
  assign bus.done = (state_q == S_DONE);
  assign bus.err  = err_q;

  for (genvar i = 0; i < N; i++) begin : g_y
    assign bus.y_out[i*W +: W] = y_m[i];
  end
endmodule

// File: tb/tb_tri_solve_nxn.sv
// Self-checking bench for tri_solve_nxn: directed vector table, random solves against
// a substitution model, and control-sequence corner cases; plus an N=2, W=16 instance.
module tb_tri_solve_nxn;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tri_solve_if #(.N(4), .W(32)) bus4 ();
  tri_solve_if #(.N(2), .W(16)) bus2 ();

  tri_solve_nxn #(.N(4), .W(32)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  tri_solve_nxn #(.N(2), .W(16)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int errors = 0;
  int checks = 0;

  bit cur_mode;
  int cur_a [4][4];
  int cur_b [4];
  int exp_y [4];
  bit exp_e;

  typedef struct packed {
    logic                  mode;
    logic [0:3][0:3][31:0] a;
    logic [0:3][31:0]      b;
    logic [0:3][31:0]      y;
    logic                  e;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Plain substitution in row order, y values wrapped to 32 bits as they are produced.
  task automatic model();
    exp_e = 1'b0;
    for (int i = 0; i < 4; i++) exp_y[i] = 0;
    for (int k = 0; k < 4; k++) begin
      int     i;
      longint acc;
      i   = cur_mode ? 3 - k : k;
      acc = cur_b[i];
      for (int j = 0; j < 4; j++)
        if (cur_mode ? (j > i) : (j < i)) acc -= longint'(cur_a[i][j]) * longint'(exp_y[j]);
      if (cur_a[i][i] == 0) begin
        exp_y[i] = 0;
        exp_e    = 1'b1;
      end else begin
        exp_y[i] = int'(acc / longint'(cur_a[i][i]));
      end
    end
  endtask

  task automatic load_vec(input int k);
    cur_mode = vecs[k].mode;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) cur_a[r][c] = vecs[k].a[r][c];
      cur_b[r] = vecs[k].b[r];
      exp_y[r] = vecs[k].y[r];
    end
    exp_e = vecs[k].e;
  endtask

  task automatic drive_start();
    bus4.mode = cur_mode;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) bus4.A_in[(r*4+c)*32 +: 32] = cur_a[r][c];
      bus4.b_in[r*32 +: 32] = cur_b[r];
    end
    bus4.start = 1'b1;
  endtask

  task automatic check_y(input string tag);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_y%0d", tag, i), longint'($signed(bus4.y_out[i*32 +: 32])), exp_y[i]);
    check({tag, "_err"}, bus4.err, exp_e);
  endtask

  // Launches at the current time (keep away from the edge); latency counts the accepting edge as 1.
  task automatic solve4(input string tag, input int glitch_at, input bit chk_width);
    int lat;
    drive_start();
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = 1;
    check({tag, "_busy_after_accept"}, bus4.busy, 1);
    while (!bus4.done && lat < 60) begin
      if (lat == glitch_at) begin
        bus4.start = 1'b1;
        bus4.b_in  = ~bus4.b_in;
        bus4.mode  = ~cur_mode;
      end
      @(posedge clk); #1;
      bus4.start = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, lat, 11);
    check({tag, "_busy_at_done"}, bus4.busy, 0);
    check_y(tag);
    if (chk_width) begin
      @(posedge clk); #1;
      check({tag, "_done_width"}, bus4.done, 0);
    end
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int nd = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (bus4.done) nd++;
    end
    check(tag, nd, 0);
  endtask

  initial begin
    int lat2;

    vecs[0].mode = 1'b0;
    vecs[0].a    = '{'{2,0,0,0}, '{1,3,0,0}, '{2,4,2,0}, '{1,2,3,4}};
    vecs[0].b    = '{4, 11, 18, 27};
    vecs[0].y    = '{2, 3, 1, 4};
    vecs[0].e    = 1'b0;
    vecs[1].mode = 1'b0;
    vecs[1].a    = '{'{2,0,0,0}, '{1,3,0,0}, '{2,4,2,0}, '{1,2,3,4}};
    vecs[1].b    = '{4, 13, 14, 28};
    vecs[1].y    = '{2, 3, -1, 5};
    vecs[1].e    = 1'b0;
    vecs[2].mode = 1'b1;
    vecs[2].a    = '{'{2,1,2,1}, '{0,3,4,2}, '{0,0,2,3}, '{0,0,0,4}};
    vecs[2].b    = '{14, 26, 18, 16};
    vecs[2].y    = '{1, 2, 3, 4};
    vecs[2].e    = 1'b0;
    vecs[3].mode = 1'b0;
    vecs[3].a    = '{'{2,0,0,0}, '{1,0,0,0}, '{2,4,2,0}, '{1,2,3,4}};
    vecs[3].b    = '{4, 13, 14, 28};
    vecs[3].y    = '{2, 0, 5, 2};
    vecs[3].e    = 1'b1;

    bus4.start = 1'b0; bus4.mode = 1'b0; bus4.A_in = '0; bus4.b_in = '0;
    bus2.start = 1'b0; bus2.mode = 1'b0; bus2.A_in = '0; bus2.b_in = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus4.busy, 0);
    check("rst_done", bus4.done, 0);
    check("rst_err", bus4.err, 0);
    check("rst_y_nonzero", bus4.y_out != '0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table; vec3 (err=1) is followed by vec0 below, which must clear err.
    for (int k = 0; k < 4; k++) begin
      load_vec(k);
      solve4($sformatf("vec%0d", k), 0, 1'b1);
    end
    load_vec(0);
    solve4("err_clear", 0, 1'b1);

    repeat (25) begin
      cur_mode = 1'($urandom_range(0, 1));
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) cur_a[r][c] = int'($urandom_range(0, 200)) - 100;
        if ($urandom_range(0, 7) == 0) cur_a[r][r] = 0;
        cur_b[r] = int'($urandom_range(0, 20000)) - 10000;
      end
      model();
      solve4("rnd", 0, 1'b0);
    end

    // Start pulsed mid-solve with altered operands must be ignored.
    load_vec(0);
    solve4("glitch", 4, 1'b1);
    count_dones("glitch_extra_done", 20);
    check_y("glitch_hold");

    // Back-to-back: second start asserted during the DONE cycle.
    load_vec(1);
    solve4("b2b_a", 0, 1'b0);
    load_vec(2);
    solve4("b2b_b", 0, 1'b1);

    // Reset mid-solve after the zero diagonal has set err.
    load_vec(3);
    drive_start();
    @(posedge clk); #1;
    bus4.start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", bus4.busy, 1);
    check("pre_rst_err", bus4.err, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", bus4.busy, 0);
    check("mid_rst_done", bus4.done, 0);
    check("mid_rst_err", bus4.err, 0);
    check("mid_rst_y_nonzero", bus4.y_out != '0, 0);
    rst = 1'b0;
    count_dones("post_rst_done", 20);
    load_vec(0);
    solve4("post_rst", 0, 1'b1);

    // N=2, W=16 instance.
    bus2.mode  = 1'b0;
    bus2.A_in  = {16'sd5, -16'sd2, 16'sd0, 16'sd3};
    bus2.b_in  = {-16'sd1, 16'sd9};
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    lat2 = 1;
    while (!bus2.done && lat2 < 30) begin
      @(posedge clk); #1;
      lat2++;
    end
    check("n2_latency", lat2, 4);
    check("n2_y0", longint'($signed(bus2.y_out[15:0])), 3);
    check("n2_y1", longint'($signed(bus2.y_out[31:16])), 1);
    check("n2_err", bus2.err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
